// File: rtl/sign_job_scheduler.sv
// Two-requester signing front end: round-robin grant, then Keccak digest and ECDSA sign
// via external engines, with per-wait timeout and a one-cycle response pulse.
module sign_job_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [255:0] msg0,
  input  logic [255:0] msg1,
  input  logic [255:0] priv_key,
  input  logic [255:0] nonce_in,
  output logic [1:0]   grant,
  output logic [1:0]   resp_valid,
  output logic         resp_err,
  output logic [519:0] sig_out,
  output logic         hash_start,
  output logic [255:0] hash_msg,
  input  logic         hash_done,
  input  logic [255:0] hash_digest,
  output logic         ecdsa_start,
  output logic [255:0] ecdsa_msg,
  output logic [255:0] ecdsa_priv_key,
  output logic [255:0] ecdsa_nonce,
  input  logic         ecdsa_done,
  input  logic         ecdsa_error,
  input  logic [519:0] ecdsa_sig
);

  typedef enum logic [2:0] {
    IDLE, HASH_START, HASH_WAIT, SIGN_START, SIGN_WAIT, RESPOND
  } state_e;

  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          prio_q, prio_d;
  logic [255:0]  msg_q, msg_d, key_q, key_d, nonce_q, nonce_d, digest_q, digest_d;
  logic [519:0]  sig_q, sig_d;
  logic          err_q, err_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          win;
  logic          v_ok;

  assign v_ok = (ecdsa_sig[7:0] == 8'd27) || (ecdsa_sig[7:0] == 8'd28);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      prio_q   <= 1'b0;
      msg_q    <= '0;
      key_q    <= '0;
      nonce_q  <= '0;
      digest_q <= '0;
      sig_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      prio_q   <= prio_d;
      msg_q    <= msg_d;
      key_q    <= key_d;
      nonce_q  <= nonce_d;
      digest_q <= digest_d;
      sig_q    <= sig_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    prio_d   = prio_q;
    msg_d    = msg_q;
    key_d    = key_q;
    nonce_d  = nonce_q;
    digest_d = digest_q;
    sig_d    = sig_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    win      = 1'b0;
    unique case (state_q)
      IDLE: if (|req) begin
        // prio_q names the requester that wins a tie
        win      = (req == 2'b11) ? prio_q : req[1];
        grant_d  = win ? 2'b10 : 2'b01;
        msg_d    = win ? msg1 : msg0;
        key_d    = priv_key;
        nonce_d  = nonce_in;
        digest_d = '0;
        sig_d    = '0;
        err_d    = 1'b0;
        state_d  = HASH_START;
      end
      HASH_START: begin
        cnt_d = '0;
        if (key_q == '0) begin
          err_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          state_d = HASH_WAIT;
        end
      end
      HASH_WAIT: begin
        if (hash_done) begin
          digest_d = hash_digest;
          state_d  = SIGN_START;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SIGN_START: begin
        cnt_d   = '0;
        state_d = SIGN_WAIT;
      end
      SIGN_WAIT: begin
        if (ecdsa_error) begin
          err_d   = 1'b1;
          state_d = RESPOND;
        end else if (ecdsa_done) begin
          // a recovery id other than 27/28 means the signer produced garbage
          err_d   = !v_ok;
          sig_d   = v_ok ? ecdsa_sig : '0;
          state_d = RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESPOND: begin
        prio_d  = ~grant_q[1];
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant          = grant_q;
  assign resp_valid     = (state_q == RESPOND) ? grant_q : 2'b00;
  assign resp_err       = err_q;
  assign sig_out        = sig_q;
  assign hash_start     = (state_q == HASH_START) && (key_q != '0);
  assign hash_msg       = msg_q;
  assign ecdsa_start    = (state_q == SIGN_START);
  assign ecdsa_msg      = digest_q;
  assign ecdsa_priv_key = key_q;
  assign ecdsa_nonce    = nonce_q;

endmodule
